uart_rx_fifo: RTL and testbench

//   Receive buffer downstream of the UART receiver. Captures one word per

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: one word captured per ready rising edge,
// stored in a circular FIFO and presented through a fall-through valid/ready read port.
module uart_rx_fifo #(
  parameter int unsigned Word_Len   = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_data_in_ready,
  input  logic [Word_Len-1:0]           rx_data_in,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [Word_Len-1:0]           rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] PtrOne    = 1;
  localparam logic [ADDR_W:0]   CntOne    = 1;
  localparam logic [ADDR_W:0]   CntZero   = '0;
  localparam logic [ADDR_W:0]   CntDepth  = FIFO_DEPTH[ADDR_W:0];

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic                 ready_q, ready_d;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic [Word_Len-1:0]  mem_q [FIFO_DEPTH];

  logic wr_req;
  logic pop;
  logic wr_en;
  logic drop;

  // Only the rising edge of the ready level counts, so a long stop bit writes once.
  assign wr_req = rx_data_in_ready & ~ready_q;
  assign pop    = ~empty_q & rd_ready;
  // When full, a same-cycle pop frees the slot the new word lands in.
  assign wr_en  = wr_req & (~full_q | pop);
  assign drop   = wr_req & full_q & ~pop;

  always_comb begin
    ready_d    = rx_data_in_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == CntDepth);
    empty_d = (count_d == CntZero);

    // A drop in the same cycle as a clear must remain visible.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are only observable while rd_valid is high.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= rx_data_in;
    end
  end

  assign rd_valid   = ~empty_q;
  assign rd_data    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized stream
// checked against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

  localparam int Depth = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_in_ready = 1'b1;
  logic [7:0] rx_data_in = 8'h00;
  logic       rd_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words in arrival order, previous ready level, sticky flag.
  logic [7:0] mq[$];
  logic       m_rdy_prev = 1'b1;
  logic       m_ovf = 1'b0;

  uart_rx_fifo #(.Word_Len(8), .FIFO_DEPTH(Depth)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data_in_ready (rx_data_in_ready),
    .rx_data_in       (rx_data_in),
    .rd_ready         (rd_ready),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .fifo_count       (fifo_count),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .overflow         (overflow),
    .clr_overflow     (clr_overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic cycle();
    logic new_frame;
    logic dropped;
    if (reset) begin
      mq.delete();
      m_rdy_prev = 1'b1;
      m_ovf = 1'b0;
    end else begin
      new_frame = rx_data_in_ready && !m_rdy_prev;
      dropped = 1'b0;
      if (rd_ready && mq.size() != 0) void'(mq.pop_front());
      if (new_frame) begin
        if (mq.size() < Depth) mq.push_back(rx_data_in);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      m_rdy_prev = rx_data_in_ready;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    rx_data_in_ready = 1'b1;
    rx_data_in = d;
    cycle();
    rx_data_in_ready = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_data_in_ready = 1'b1;
    rx_data_in = 8'h3C;
    cycle();
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== 5'd0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_capture: empty=%b count=%0d valid=%b, required 1/0/0",
               fifo_empty, fifo_count, rd_valid);
    end
    checks++;
    if (fifo_full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: full=%b overflow=%b, required 0/0", fifo_full, overflow);
    end
    rx_data_in_ready = 1'b0;
    cycle();
  endtask

  task automatic test_long_frame();
    rx_data_in_ready = 1'b1;
    rx_data_in = 8'hA5;
    cycle();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL long_first: valid=%b data=%h count=%0d, required 1/a5/1",
               rd_valid, rd_data, fifo_count);
    end
    repeat (5207) begin
      rx_data_in = 8'($urandom);
      cycle();
    end
    rx_data_in_ready = 1'b0;
    cycle();
    checks++;
    if (fifo_count !== 5'd1 || rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL long_single_write: count=%0d data=%h, required 1/a5", fifo_count, rd_data);
    end
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
      errors++;
      $display("FAIL long_pop: empty=%b valid=%b count=%0d, required 1/0/0",
               fifo_empty, rd_valid, fifo_count);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < Depth; i++) send_frame(8'(i));
    checks++;
    if (fifo_full !== 1'b1 || fifo_count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: full=%b count=%0d ovf=%b, required 1/16/0",
               fifo_full, fifo_count, overflow);
    end
    send_frame(8'h10);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL fill_drop: ovf=%b count=%0d, required 1/16", overflow, fifo_count);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        errors++;
        $display("FAIL fill_drain[%0d]: valid=%b data=%h, required 1/%h", i, rd_valid, rd_data,
                 8'(i));
      end
      cycle();
    end
    rd_ready = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_after_drain: empty=%b ovf=%b, required 1/1", fifo_empty, overflow);
    end
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_clear: ovf=%b, required 0", overflow);
    end
  endtask

  task automatic test_full_pop_write();
    logic [7:0] exp;
    for (int i = 0; i < Depth; i++) send_frame(8'(i));
    rx_data_in_ready = 1'b1;
    rx_data_in = 8'h40;
    rd_ready = 1'b1;
    cycle();
    rx_data_in_ready = 1'b0;
    rd_ready = 1'b0;
    cycle();
    checks++;
    if (fifo_count !== 5'd16 || fifo_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_state: count=%0d full=%b ovf=%b, required 16/1/0",
               fifo_count, fifo_full, overflow);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      exp = (i < Depth - 1) ? 8'(i + 1) : 8'h40;
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errors++;
        $display("FAIL fullpop_drain[%0d]: valid=%b data=%h, required 1/%h", i, rd_valid,
                 rd_data, exp);
      end
      cycle();
    end
    rd_ready = 1'b0;
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_empty: empty=%b, required 1", fifo_empty);
    end
  endtask

  task automatic test_stream();
    logic       rdy_seq[$];
    logic [7:0] dat_seq[$];
    logic [7:0] sent[$];
    logic [7:0] got[$];
    logic [7:0] w;
    int         bad = 0;
    for (int n = 0; n < 40; n++) begin
      w = 8'($urandom);
      sent.push_back(w);
      repeat ($urandom_range(1, 3)) begin
        rdy_seq.push_back(1'b1);
        dat_seq.push_back(w);
      end
      repeat ($urandom_range(1, 2)) begin
        rdy_seq.push_back(1'b0);
        dat_seq.push_back(8'($urandom));
      end
    end
    for (int c = 0; c < rdy_seq.size() + 20; c++) begin
      if (c < rdy_seq.size()) begin
        rx_data_in_ready = rdy_seq[c];
        rx_data_in = dat_seq[c];
        rd_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rx_data_in_ready = 1'b0;
        rd_ready = 1'b1;
      end
      checks++;
      if (fifo_count !== 5'(mq.size()) || rd_valid !== (mq.size() != 0) ||
          (mq.size() != 0 && rd_data !== mq[0]) || overflow !== 1'b0 ||
          fifo_count > 5'd16) begin
        bad++;
        errors++;
        $display("FAIL stream_cycle[%0d]: count=%0d valid=%b data=%h ovf=%b, required %0d/%b/%h/0",
                 c, fifo_count, rd_valid, rd_data, overflow, mq.size(), mq.size() != 0,
                 (mq.size() != 0) ? mq[0] : 8'h00);
      end
      if (rd_valid === 1'b1 && rd_ready) got.push_back(rd_data);
      cycle();
    end
    rd_ready = 1'b0;
    checks++;
    if (got.size() != sent.size()) begin
      errors++;
      $display("FAIL stream_count: got %0d words, required %0d", got.size(), sent.size());
    end else begin
      for (int i = 0; i < sent.size(); i++) begin
        checks++;
        if (got[i] !== sent[i]) begin
          errors++;
          $display("FAIL stream_order[%0d]: got %h, required %h", i, got[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_clr_collision();
    for (int i = 0; i < Depth; i++) send_frame(8'($urandom));
    rx_data_in_ready = 1'b1;
    rx_data_in = 8'h77;
    clr_overflow = 1'b1;
    cycle();
    rx_data_in_ready = 1'b0;
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      errors++;
      $display("FAIL clr_collision: ovf=%b, required 1", overflow);
    end
    cycle();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL clr_hold: ovf=%b, required 1", overflow);
    end
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL clr_alone: ovf=%b count=%0d, required 0/16", overflow, fifo_count);
    end
  endtask

  task automatic test_reset_midstream();
    rx_data_in_ready = 1'b1;
    rx_data_in = 8'h5A;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (fifo_empty !== 1'b1 || fifo_count !== 5'd0 || fifo_full !== 1'b0 ||
        rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset: empty=%b count=%0d full=%b valid=%b, required 1/0/0/0",
               fifo_empty, fifo_count, fifo_full, rd_valid);
    end
    rx_data_in_ready = 1'b0;
    cycle();
    send_frame(8'hC3);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL midreset_after: valid=%b data=%h count=%0d, required 1/c3/1",
               rd_valid, rd_data, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_long_frame();
    test_fill_overflow();
    test_full_pop_write();
    test_stream();
    test_clr_collision();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
